// File: rtl/array_pkg.sv
// Shared definitions for the parametrised single-port masked array family:
// sweep/ready state encoding and the address-width helper.
package array_pkg;

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } array_state_e;

    // Smallest r with 2**r >= n; used to size the word address.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/array_rd_pipe.sv
// Read-return pipeline: LAT register stages for data and valid. Only the valid
// chain and the final output word are reset; intermediate data is free-running.
module array_rd_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LAT   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic             last_vld;
    logic [WIDTH-1:0] last_dat;
    logic             rvalid_q;
    logic [WIDTH-1:0] rdata_q;

    if (LAT > 1) begin : g_mid
        logic [LAT-2:0]   mvld_q;
        logic [WIDTH-1:0] mid_q [LAT-1];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                mvld_q <= '0;
            end else begin
                mvld_q[0] <= in_valid;
                for (int s = 1; s < int'(LAT) - 1; s++) begin
                    mvld_q[s] <= mvld_q[s-1];
                end
            end
        end

        always_ff @(posedge clk) begin
            mid_q[0] <= in_data;
            for (int s = 1; s < int'(LAT) - 1; s++) begin
                mid_q[s] <= mid_q[s-1];
            end
        end

        assign last_vld = mvld_q[LAT-2];
        assign last_dat = mid_q[LAT-2];
    end else begin : g_direct
        assign last_vld = in_valid;
        assign last_dat = in_data;
    end

    // Output word only moves when a read completes, so it holds between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= last_vld;
            if (last_vld) begin
                rdata_q <= last_dat;
            end
        end
    end

    assign out_valid = rvalid_q;
    assign out_data  = rdata_q;

endmodule

// File: rtl/array_sp_init_ext.sv
// Single-port byte-group-masked SRAM model with a zero-initialisation sweep,
// ready gating and a 1- or 2-cycle registered read return.
module array_sp_init_ext
    import array_pkg::*;
#(
    parameter int unsigned DEPTH         = 128,
    parameter int unsigned WIDTH         = 1316,
    parameter int unsigned MASK_SEG      = 4,
    parameter int unsigned READ_LAT      = 1,
    parameter bit          INIT_ON_RESET = 1'b1,
    parameter int unsigned AW            = clog2(DEPTH)
) (
    input  logic                RW0_clk,
    input  logic                RW0_reset,
    input  logic                RW0_en,
    input  logic                RW0_wmode,
    input  logic [AW-1:0]       RW0_addr,
    input  logic [MASK_SEG-1:0] RW0_wmask,
    input  logic [WIDTH-1:0]    RW0_wdata,
    input  logic                init_req,
    output logic                RW0_ready,
    output logic [WIDTH-1:0]    RW0_rdata,
    output logic                RW0_rvalid,
    output logic                init_done
);

    localparam int unsigned   G       = WIDTH / MASK_SEG;
    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    array_state_e     state_q;
    logic [AW-1:0]    ptr_q;
    logic             ready_q;
    logic             done_q;

    logic [WIDTH-1:0] mem [DEPTH];

    logic             addr_ok;
    logic             wr_acc;
    logic             rd_acc;
    logic [WIDTH-1:0] rd_word;

    assign addr_ok = {1'b0, RW0_addr} < DEPTH_W;
    assign wr_acc  = RW0_en && ready_q && RW0_wmode;
    assign rd_acc  = RW0_en && ready_q && !RW0_wmode;

    // Sweep/ready FSM; ready and init_done are registered alongside the state.
    always_ff @(posedge RW0_clk or posedge RW0_reset) begin
        if (RW0_reset) begin
            state_q <= INIT_ON_RESET ? ST_INIT : ST_READY;
            ptr_q   <= '0;
            ready_q <= 1'b0;
            done_q  <= !INIT_ON_RESET;
        end else begin
            case (state_q)
                ST_INIT: begin
                    ready_q <= 1'b0;
                    done_q  <= 1'b0;
                    ptr_q   <= ptr_q + AW'(1);
                    if (ptr_q == LAST) begin
                        state_q <= ST_READY;
                        ptr_q   <= '0;
                        ready_q <= 1'b1;
                        done_q  <= 1'b1;
                    end
                end
                ST_READY: begin
                    ready_q <= 1'b1;
                    done_q  <= 1'b1;
                    if (init_req) begin
                        state_q <= ST_INIT;
                        ptr_q   <= '0;
                        ready_q <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Storage: sweep zeroing has priority; accesses are only accepted in READY.
    always_ff @(posedge RW0_clk) begin
        if (state_q == ST_INIT) begin
            mem[ptr_q] <= '0;
        end else if (wr_acc && addr_ok) begin
            for (int i = 0; i < int'(MASK_SEG); i++) begin
                if (RW0_wmask[i]) begin
                    mem[RW0_addr][i*G +: G] <= RW0_wdata[i*G +: G];
                end
            end
        end
    end

    always_comb begin
        rd_word = '0;
        if (addr_ok) begin
            rd_word = mem[RW0_addr];
        end
    end

    array_rd_pipe #(
        .WIDTH (WIDTH),
        .LAT   (READ_LAT)
    ) u_rd_pipe (
        .clk       (RW0_clk),
        .rst       (RW0_reset),
        .in_valid  (rd_acc),
        .in_data   (rd_word),
        .out_valid (RW0_rvalid),
        .out_data  (RW0_rdata)
    );

    assign RW0_ready = ready_q;
    assign init_done = done_q;

endmodule

// File: tb/tb_array_sp_init_ext.sv
// Self-checking bench for array_sp_init_ext: table vectors, directed sweep/reset
// sequences and random traffic against a word-array reference model.
module tb_array_sp_init_ext;

    localparam int DEPTH    = 128;
    localparam int W        = 1316;
    localparam int SEG      = 4;
    localparam int G        = W / SEG;
    localparam int READ_LAT = 1;

    logic           RW0_clk = 1'b0;
    logic           RW0_reset;
    logic           RW0_en;
    logic           RW0_wmode;
    logic [6:0]     RW0_addr;
    logic [SEG-1:0] RW0_wmask;
    logic [W-1:0]   RW0_wdata;
    logic           init_req;
    logic           RW0_ready;
    logic [W-1:0]   RW0_rdata;
    logic           RW0_rvalid;
    logic           init_done;

    always #5 RW0_clk = ~RW0_clk;

    array_sp_init_ext #(
        .DEPTH         (DEPTH),
        .WIDTH         (W),
        .MASK_SEG      (SEG),
        .READ_LAT      (READ_LAT),
        .INIT_ON_RESET (1'b1)
    ) dut (
        .RW0_clk    (RW0_clk),
        .RW0_reset  (RW0_reset),
        .RW0_en     (RW0_en),
        .RW0_wmode  (RW0_wmode),
        .RW0_addr   (RW0_addr),
        .RW0_wmask  (RW0_wmask),
        .RW0_wdata  (RW0_wdata),
        .init_req   (init_req),
        .RW0_ready  (RW0_ready),
        .RW0_rdata  (RW0_rdata),
        .RW0_rvalid (RW0_rvalid),
        .init_done  (init_done)
    );

    typedef struct {
        int           due;
        logic [W-1:0] d;
    } rd_t;

    typedef struct {
        logic       en;
        logic       wm;
        logic [6:0] a;
        logic [3:0] mk;
        int         dsel;
        logic       ev;
        int         esel;
    } vec_t;

    // Reference model: word array, remaining sweep edges, pending read returns.
    logic [W-1:0] m_mem [DEPTH];
    rd_t          rq[$];
    int           left;
    int           edge_k;
    logic [W-1:0] exp_d;
    int           n_rv;

    int n_vec = 0;
    int n_bad = 0;

    logic [W-1:0] ONES, ZERO, PAT;
    vec_t         tbl[12];

    function automatic void chk(input string nm, input logic [W-1:0] act,
                                input logic [W-1:0] exp);
        logic [1343:0] pa, pe;
        int            wi;
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            pa = 1344'(act);
            pe = 1344'(exp);
            wi = 0;
            for (int i = 41; i >= 0; i--) begin
                if (pa[i*32 +: 32] !== pe[i*32 +: 32]) wi = i;
            end
            $display("FAIL %s: got %h required %h (32-bit word %0d)", nm,
                     pa[wi*32 +: 32], pe[wi*32 +: 32], wi);
        end
    endfunction

    function automatic logic [W-1:0] sel_word(input int s);
        case (s)
            1:       return ONES;
            2:       return PAT;
            default: return ZERO;
        endcase
    endfunction

    function automatic logic [W-1:0] rnd_word();
        logic [1343:0] r;
        for (int i = 0; i < 42; i++) r[i*32 +: 32] = $urandom;
        return r[W-1:0];
    endfunction

    // One clock with the given request; model updated at the edge, DUT checked #1 after.
    task automatic cycle(input logic en, input logic wm, input logic [6:0] a,
                         input logic [3:0] mk, input logic [W-1:0] d, input logic ir);
        logic acc;
        rd_t  e;
        logic ev;
        RW0_en    = en;
        RW0_wmode = wm;
        RW0_addr  = a;
        RW0_wmask = mk;
        RW0_wdata = d;
        init_req  = ir;
        acc = en && (left == 0);
        if (acc && wm) begin
            for (int i = 0; i < SEG; i++)
                if (mk[i]) m_mem[a][i*G +: G] = d[i*G +: G];
        end
        if (acc && !wm) begin
            e.due = edge_k + READ_LAT - 1;
            e.d   = m_mem[a];
            rq.push_back(e);
        end
        if (left > 0) begin
            left--;
        end else if (ir) begin
            left = DEPTH;
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        end
        @(posedge RW0_clk);
        #1;
        ev = 1'b0;
        if (rq.size() > 0 && rq[0].due == edge_k) begin
            ev    = 1'b1;
            exp_d = rq[0].d;
            void'(rq.pop_front());
        end
        edge_k++;
        if (RW0_rvalid === 1'b1) n_rv++;
        chk("ready", W'(RW0_ready), W'(left == 0));
        chk("init_done", W'(init_done), W'(left == 0));
        chk("rvalid", W'(RW0_rvalid), W'(ev));
        chk("rdata", RW0_rdata, exp_d);
        RW0_en   = 1'b0;
        init_req = 1'b0;
    endtask

    task automatic do_reset();
        RW0_en    = 1'b0;
        init_req  = 1'b0;
        RW0_reset = 1'b1;
        rq.delete();
        exp_d = '0;
        left  = DEPTH;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        #1;
        chk("rst rvalid", W'(RW0_rvalid), W'(0));
        chk("rst rdata", RW0_rdata, ZERO);
        chk("rst ready", W'(RW0_ready), W'(0));
        chk("rst init_done", W'(init_done), W'(0));
        repeat (3) @(posedge RW0_clk);
        #1;
        RW0_reset = 1'b0;
        edge_k    = 0;
    endtask

    // Counts edges with ready low while hammering dropped requests.
    task automatic sweep_count(input string nm);
        int n;
        n = 0;
        while (RW0_ready !== 1'b1 && n < DEPTH + 16) begin
            cycle(1'b1, 1'($urandom_range(1, 0)), 7'($urandom_range(DEPTH - 1, 0)),
                  4'($urandom), ONES, 1'b0);
            n++;
        end
        chk(nm, W'(n), W'(DEPTH));
    endtask

    initial begin
        ONES = '1;
        ZERO = '0;
        PAT  = '0;
        PAT[328:0]   = '1;
        PAT[986:658] = '1;

        tbl[0]  = '{1'b1, 1'b1, 7'd5, 4'b0101, 1, 1'b0, 0};
        tbl[1]  = '{1'b1, 1'b0, 7'd5, 4'b0000, 0, 1'b1, 2};
        tbl[2]  = '{1'b0, 1'b0, 7'd0, 4'b0000, 0, 1'b0, 2};
        tbl[3]  = '{1'b1, 1'b0, 7'd5, 4'b0000, 0, 1'b1, 2};
        tbl[4]  = '{1'b1, 1'b1, 7'd5, 4'b1111, 0, 1'b0, 2};
        tbl[5]  = '{1'b1, 1'b0, 7'd5, 4'b0000, 0, 1'b1, 0};
        tbl[6]  = '{1'b1, 1'b1, 7'd9, 4'b1111, 1, 1'b0, 0};
        tbl[7]  = '{1'b1, 1'b1, 7'd9, 4'b0000, 0, 1'b0, 0};
        tbl[8]  = '{1'b1, 1'b0, 7'd9, 4'b0000, 0, 1'b1, 1};
        tbl[9]  = '{1'b1, 1'b0, 7'd5, 4'b0000, 0, 1'b1, 0};
        tbl[10] = '{1'b1, 1'b1, 7'd5, 4'b0101, 1, 1'b0, 0};
        tbl[11] = '{1'b1, 1'b0, 7'd5, 4'b0000, 0, 1'b1, 2};

        RW0_wmode = 1'b0;
        RW0_addr  = '0;
        RW0_wmask = '0;
        RW0_wdata = '0;

        // Boot sweep, then every word reads back zero with one rvalid each.
        do_reset();
        sweep_count("boot sweep length");
        n_rv = 0;
        for (int a = 0; a < DEPTH; a++) cycle(1'b1, 1'b0, 7'(a), 4'b0000, ZERO, 1'b0);
        repeat (READ_LAT + 1) cycle(1'b0, 1'b0, 7'd0, 4'b0000, ZERO, 1'b0);
        chk("scan rvalid count", W'(n_rv), W'(DEPTH));

        // Table vectors: masked writes, stable rdata across writes, back-to-back reads.
        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].en, tbl[i].wm, tbl[i].a, tbl[i].mk, sel_word(tbl[i].dsel), 1'b0);
            chk($sformatf("tbl%0d rvalid", i), W'(RW0_rvalid), W'(tbl[i].ev));
            chk($sformatf("tbl%0d rdata", i), RW0_rdata, sel_word(tbl[i].esel));
        end

        // Random traffic over a small address window, with occasional re-sweeps.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(3, 0) != 0), 1'($urandom_range(1, 0)),
                  7'($urandom_range(15, 0)), 4'($urandom), rnd_word(),
                  1'($urandom_range(49, 0) == 0));
        end
        for (int i = 0; i < DEPTH + 4 && left > 0; i++)
            cycle(1'b0, 1'b0, 7'd0, 4'b0000, ZERO, 1'b0);

        // init_req with a read: pre-sweep data returns, then a full sweep zeroes memory.
        cycle(1'b1, 1'b1, 7'd5, 4'b1111, PAT, 1'b0);
        cycle(1'b1, 1'b0, 7'd5, 4'b0000, ZERO, 1'b1);
        chk("init_req read rvalid", W'(RW0_rvalid), W'(1));
        chk("init_req read rdata", RW0_rdata, PAT);
        sweep_count("init_req sweep length");
        cycle(1'b1, 1'b0, 7'd5, 4'b0000, ZERO, 1'b0);
        chk("post-sweep read", RW0_rdata, ZERO);

        // Reset mid-read, then reset mid-sweep at ptr 60.
        cycle(1'b1, 1'b1, 7'd9, 4'b1111, ONES, 1'b0);
        cycle(1'b1, 1'b0, 7'd9, 4'b0000, ZERO, 1'b0);
        chk("pre-reset read", RW0_rdata, ONES);
        do_reset();
        repeat (60) cycle(1'b0, 1'b0, 7'd0, 4'b0000, ZERO, 1'b0);
        do_reset();
        sweep_count("restarted sweep length");
        cycle(1'b1, 1'b0, 7'd9, 4'b0000, ZERO, 1'b0);
        chk("post-reset read", RW0_rdata, ZERO);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
